// File: rtl/cdc_clear_requester_pkg.sv
// Shared types and limits for the CDC clear requester.
// Holds the sequencer state encoding and the minimum watchdog length.
package cdc_clear_requester_pkg;

    localparam int unsigned MIN_TIMEOUT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ISSUE,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cdc_clear_requester_buf.sv
// One-entry valid/ready register slice with a synchronous flush.
// Ports: in_* upstream handshake, out_* downstream handshake, flush_i drops the entry.
module cdc_clear_requester_buf
    import cdc_clear_requester_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic                  full_d, full_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;

    // Refill in the same cycle the current entry leaves.
    assign in_ready_o  = !full_q || out_ready_i;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q && out_ready_i) begin
            full_d = 1'b0;
        end
        if (in_valid_i && in_ready_o) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
        if (flush_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/cdc_clear_requester.sv
// Drains a one-entry payload buffer, then runs a clear handshake with a CDC source.
// Ports: clear_req_i/busy_o/clear_done_o/timeout_o control, valid/ready/data upstream, cdc_* toward the CDC.
module cdc_clear_requester
    import cdc_clear_requester_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_req_i,
    output logic                  busy_o,
    output logic                  clear_done_o,
    output logic                  timeout_o,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  cdc_valid_o,
    input  logic                  cdc_ready_i,
    output logic [DATA_WIDTH-1:0] cdc_data_o,
    output logic                  cdc_clear_o,
    input  logic                  cdc_clear_pending_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    if (TIMEOUT_CYCLES < MIN_TIMEOUT_CYCLES) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least %0d", MIN_TIMEOUT_CYCLES);
    end

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             timeout_d, timeout_q;
    logic             flush;
    logic             expire;
    logic             buf_in_ready;

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Upstream is only accepted while idle and the CDC is not clearing.
    assign ready_o = rst_ni && (state_q == ST_IDLE)
                     && !cdc_clear_pending_i && buf_in_ready;

    cdc_clear_requester_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .in_valid_i  (valid_i && ready_o),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (data_i),
        .out_valid_o (cdc_valid_o),
        .out_ready_i (cdc_ready_i),
        .out_data_o  (cdc_data_o)
    );

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        flush     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d   = ST_DRAIN;
                    timeout_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!cdc_valid_o) begin
                    state_d = ST_ISSUE;
                end else if (expire) begin
                    flush     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (cdc_clear_pending_i) begin
                    state_d = ST_WAIT_FALL;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_FALL: begin
                if (!cdc_clear_pending_i) begin
                    state_d = ST_DONE;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Each wait phase gets a fresh watchdog window.
        if (state_d != state_q || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign clear_done_o = (state_q == ST_DONE);
    assign cdc_clear_o  = (state_q == ST_ISSUE);
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_cdc_clear_requester.sv
// Scoreboard bench for cdc_clear_requester with an 8-cycle watchdog.
// Directed scenarios push expected payloads and sequence outcomes; a monitor checks them.
module tb_cdc_clear_requester;

    logic       clk;
    logic       rst_n;
    logic       clear_req_i;
    logic       busy_o;
    logic       clear_done_o;
    logic       timeout_o;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       cdc_valid_o;
    logic       cdc_ready_i;
    logic [7:0] cdc_data_o;
    logic       cdc_clear_o;
    logic       pend;

    typedef struct {
        logic done;
        int   clr;
        logic to;
    } outcome_t;

    logic [7:0] dq[$];
    outcome_t   oq[$];

    int total = 0;
    int bad   = 0;

    cdc_clear_requester #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .clear_req_i         (clear_req_i),
        .busy_o              (busy_o),
        .clear_done_o        (clear_done_o),
        .timeout_o           (timeout_o),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .data_i              (data_i),
        .cdc_valid_o         (cdc_valid_o),
        .cdc_ready_i         (cdc_ready_i),
        .cdc_data_o          (cdc_data_o),
        .cdc_clear_o         (cdc_clear_o),
        .cdc_clear_pending_i (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_no_clr_with_valid : assert property (
        @(posedge clk) disable iff (!rst_n) !(cdc_valid_o && cdc_clear_o)
    ) else $error("cdc_clear_o high with cdc_valid_o");

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_outcome(input logic d, input int c, input logic t);
        outcome_t o;
        o.done = d;
        o.clr  = c;
        o.to   = t;
        oq.push_back(o);
    endtask

    // Monitor: payload handshakes and end-of-sequence outcomes.
    logic     busy_prev = 1'b0;
    int       seq_done  = 0;
    int       seq_clr   = 0;
    outcome_t got;
    logic [7:0] exp_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
            seq_done  = 0;
            seq_clr   = 0;
        end else begin
            if (cdc_valid_o && cdc_ready_i) begin
                if (dq.size() == 0) begin
                    check("unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    exp_d = dq.pop_front();
                    check("cdc_data", 32'(cdc_data_o), 32'(exp_d));
                end
            end
            if (cdc_clear_o) begin
                seq_clr++;
                check("clear_vs_valid", 32'(cdc_valid_o), 32'd0);
            end
            if (clear_done_o) seq_done++;
            if (busy_prev && !busy_o) begin
                if (oq.size() == 0) begin
                    check("unexpected_seq_end", 32'd1, 32'd0);
                end else begin
                    got = oq.pop_front();
                    check("seq_done_pulses", 32'(seq_done), 32'(got.done));
                    check("seq_clear_pulses", 32'(seq_clr), 32'(got.clr));
                    check("seq_timeout", 32'(timeout_o), 32'(got.to));
                end
                seq_done = 0;
                seq_clr  = 0;
            end
            busy_prev = busy_o;
        end
    end

    task automatic fill(input logic [7:0] d, input bit expect_out);
        valid_i = 1'b1;
        data_i  = d;
        check("fill_ready", 32'(ready_o), 32'd1);
        if (expect_out) dq.push_back(d);
        step();
        valid_i = 1'b0;
    endtask

    logic [7:0] s1_vals [3] = '{8'h00, 8'h01, 8'h01};

    initial begin
        rst_n = 1'b0;
        clear_req_i = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        cdc_ready_i = 1'b0;
        pend = 1'b0;
        step();
        step();
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(cdc_valid_o), 32'd0);
        check("rst_clear", 32'(cdc_clear_o), 32'd0);
        check("rst_done", 32'(clear_done_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        rst_n = 1'b1;
        step();

        // Streaming 0,1,1 with the CDC always ready.
        cdc_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = s1_vals[i];
            check("s1_ready", 32'(ready_o), 32'd1);
            dq.push_back(s1_vals[i]);
            step();
            check("s1_out_valid", 32'(cdc_valid_o), 32'd1);
            check("s1_out_data", 32'(cdc_data_o), 32'(s1_vals[i]));
        end
        valid_i = 1'b0;
        step();
        step();

        // Drain stalled entry, then a normal clear handshake.
        cdc_ready_i = 1'b0;
        fill(8'hA5, 1'b1);
        push_outcome(1'b1, 1, 1'b0);
        for (int c = 0; c <= 14; c++) begin
            clear_req_i = (c == 0);
            if (c >= 5) cdc_ready_i = 1'b1;
            pend = (c >= 9 && c <= 11);
            if (c == 0) check("s2_ready_full", 32'(ready_o), 32'd0);
            if (c == 1) check("s2_busy", 32'(busy_o), 32'd1);
            if (c == 5) check("s2_ready_drain", 32'(ready_o), 32'd0);
            if (c == 6) check("s2_clear_c6", 32'(cdc_clear_o), 32'd0);
            if (c == 7) check("s2_clear_c7", 32'(cdc_clear_o), 32'd1);
            if (c == 8) check("s2_clear_c8", 32'(cdc_clear_o), 32'd0);
            if (c == 12) check("s2_done_c12", 32'(clear_done_o), 32'd0);
            if (c == 13) check("s2_done_c13", 32'(clear_done_o), 32'd1);
            if (c == 14) check("s2_idle", 32'(busy_o), 32'd0);
            step();
        end

        // DRAIN watchdog: entry is discarded and the clear still goes out.
        cdc_ready_i = 1'b0;
        fill(8'h3C, 1'b0);
        push_outcome(1'b1, 1, 1'b1);
        for (int c = 0; c <= 14; c++) begin
            clear_req_i = (c == 0);
            pend = (c == 11);
            if (c == 8) check("s3_valid_c8", 32'(cdc_valid_o), 32'd1);
            if (c == 8) check("s3_timeout_c8", 32'(timeout_o), 32'd0);
            if (c == 9) check("s3_valid_c9", 32'(cdc_valid_o), 32'd0);
            if (c == 9) check("s3_clear_c9", 32'(cdc_clear_o), 32'd1);
            if (c == 9) check("s3_timeout_c9", 32'(timeout_o), 32'd1);
            if (c == 13) check("s3_done", 32'(clear_done_o), 32'd1);
            if (c == 14) check("s3_timeout_sticky", 32'(timeout_o), 32'd1);
            step();
        end

        // Pending never rises: WAIT_RISE watchdog, ignored request.
        push_outcome(1'b0, 1, 1'b1);
        for (int c = 0; c <= 12; c++) begin
            clear_req_i = (c == 0 || c == 5);
            pend = 1'b0;
            if (c == 1) check("s4_timeout_cleared", 32'(timeout_o), 32'd0);
            if (c == 2) check("s4_clear", 32'(cdc_clear_o), 32'd1);
            if (c == 10) check("s4_busy_c10", 32'(busy_o), 32'd1);
            if (c == 11) check("s4_busy_c11", 32'(busy_o), 32'd0);
            if (c == 11) check("s4_timeout", 32'(timeout_o), 32'd1);
            if (c == 12) check("s4_not_queued", 32'(busy_o), 32'd0);
            step();
        end

        // Peer-initiated clear already pending.
        pend = 1'b1;
        step();
        push_outcome(1'b1, 1, 1'b0);
        for (int c = 0; c <= 7; c++) begin
            clear_req_i = (c == 0);
            pend = (c <= 3);
            if (c == 0) check("s5_ready_pend", 32'(ready_o), 32'd0);
            if (c == 1) check("s5_timeout_cleared", 32'(timeout_o), 32'd0);
            if (c == 2) check("s5_clear", 32'(cdc_clear_o), 32'd1);
            if (c == 5) check("s5_done", 32'(clear_done_o), 32'd1);
            step();
        end

        // Request coinciding with an accepted upstream handshake.
        cdc_ready_i = 1'b0;
        push_outcome(1'b1, 1, 1'b0);
        for (int c = 0; c <= 10; c++) begin
            clear_req_i = (c == 0);
            valid_i = (c == 0);
            data_i = 8'h5A;
            if (c >= 2) cdc_ready_i = 1'b1;
            pend = (c == 6);
            if (c == 0) begin
                check("s6_ready", 32'(ready_o), 32'd1);
                dq.push_back(8'h5A);
            end
            if (c == 1) check("s6_valid", 32'(cdc_valid_o), 32'd1);
            if (c == 1) check("s6_data", 32'(cdc_data_o), 32'h5A);
            if (c == 4) check("s6_clear", 32'(cdc_clear_o), 32'd1);
            if (c == 8) check("s6_done", 32'(clear_done_o), 32'd1);
            step();
        end

        // Reset during WAIT_FALL, then a fresh sequence.
        for (int c = 0; c <= 4; c++) begin
            clear_req_i = (c == 0);
            pend = (c >= 3);
            step();
        end
        rst_n = 1'b0;
        #1;
        check("r_busy", 32'(busy_o), 32'd0);
        check("r_done", 32'(clear_done_o), 32'd0);
        check("r_timeout", 32'(timeout_o), 32'd0);
        check("r_valid", 32'(cdc_valid_o), 32'd0);
        check("r_clear", 32'(cdc_clear_o), 32'd0);
        check("r_ready", 32'(ready_o), 32'd0);
        pend = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("r_no_reissue", 32'(cdc_clear_o), 32'd0);
        push_outcome(1'b1, 1, 1'b0);
        for (int c = 0; c <= 8; c++) begin
            clear_req_i = (c == 0);
            pend = (c == 4);
            if (c == 2) check("r2_clear", 32'(cdc_clear_o), 32'd1);
            if (c == 6) check("r2_done", 32'(clear_done_o), 32'd1);
            if (c == 8) check("r2_idle", 32'(busy_o), 32'd0);
            step();
        end

        step();
        step();
        check("data_queue_empty", 32'(dq.size()), 32'd0);
        check("outcome_queue_empty", 32'(oq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
